// File: rtl/frame_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_sprite_ctrl
// Purpose  : Geometry sequencer for the rectangular frame/cursor sprite.
//            Accepts move/resize/set commands over a valid/ready handshake,
//            computes clamped targets, and slews the live x/y/width/height
//            toward them by at most STEP pixels per video frame. Live fields
//            only change on new_frame_in, so the sprite never tears.
// Ports    : clk_in, rst_n_in (async active-low)  - clock / reset
//            new_frame_in                         - start-of-vblank pulse
//            cmd_valid_in / cmd_ready_out         - command handshake
//            cmd_op_in, cmd_x_in, cmd_y_in        - opcode and SET operands
//            x_out, y_out, width_out, height_out  - live geometry (registered)
//            busy_out                             - animation in progress
// Options  : FRAME_CTRL_WRAP_EN - moves wrap around the legal range and jump
//            straight to the target instead of clamping and slewing.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sprite_ctrl #(
  parameter int SCREEN_W = 1280,
  parameter int SCREEN_H = 720,
  parameter int GRID     = 16,
  parameter int STEP     = 4,
  parameter int MIN_SIZE = 16,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0,
  parameter int W_INIT   = 64,
  parameter int H_INIT   = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        new_frame_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [2:0]  cmd_op_in,
  input  logic [10:0] cmd_x_in,
  input  logic [9:0]  cmd_y_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [10:0] width_out,
  output logic [9:0]  height_out,
  output logic        busy_out
);

  localparam logic [2:0] c_op_up     = 3'd1;
  localparam logic [2:0] c_op_down   = 3'd2;
  localparam logic [2:0] c_op_left   = 3'd3;
  localparam logic [2:0] c_op_right  = 3'd4;
  localparam logic [2:0] c_op_grow   = 3'd5;
  localparam logic [2:0] c_op_shrink = 3'd6;
  localparam logic [2:0] c_op_set    = 3'd7;

  localparam logic [11:0] c_screen_w = 12'(SCREEN_W);
  localparam logic [11:0] c_screen_h = 12'(SCREEN_H);
  localparam logic [11:0] c_grid     = 12'(GRID);
  localparam logic [11:0] c_step     = 12'(STEP);
  localparam logic [11:0] c_min_size = 12'(MIN_SIZE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ANIM = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_jump;   // pending move wrapped: land on target without slew
  logic [10:0] r_x, r_w, r_tx, r_tw;
  logic [9:0]  r_y, r_h, r_ty, r_th;

  function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [11:0] max12(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a : b;
  endfunction

  // Subtraction that floors at zero instead of wrapping.
  function automatic logic [11:0] sub0(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : 12'd0;
  endfunction

  // Move one field toward its target by at most STEP.
  function automatic logic [11:0] slew(input logic [11:0] live, input logic [11:0] tgt);
    if (tgt > live)
      return ((tgt - live) > c_step) ? (live + c_step) : tgt;
    else
      return ((live - tgt) > c_step) ? (live - c_step) : tgt;
  endfunction

  // 12-bit views of the current targets and the room each one leaves.
  logic [11:0] w_tx, w_ty, w_tw, w_th;
  logic [11:0] w_x_max, w_y_max, w_w_max, w_h_max;

  assign w_tx    = {1'b0, r_tx};
  assign w_ty    = {2'b00, r_ty};
  assign w_tw    = {1'b0, r_tw};
  assign w_th    = {2'b00, r_th};
  assign w_x_max = c_screen_w - w_tw;
  assign w_y_max = c_screen_h - w_th;
  assign w_w_max = c_screen_w - w_tx;
  assign w_h_max = c_screen_h - w_ty;

  // Next targets for the command on the bus.
  logic [11:0] w_nx, w_ny, w_nw, w_nh;
  logic        w_jump;

  always_comb begin
    w_nx   = w_tx;
    w_ny   = w_ty;
    w_nw   = w_tw;
    w_nh   = w_th;
    w_jump = 1'b0;
    case (cmd_op_in)
`ifdef FRAME_CTRL_WRAP_EN
      c_op_up: begin
        if (w_ty < c_grid) begin
          w_ny   = w_y_max;
          w_jump = 1'b1;
        end else begin
          w_ny = w_ty - c_grid;
        end
      end
      c_op_down: begin
        if ((w_ty + c_grid) > w_y_max) begin
          w_ny   = 12'd0;
          w_jump = 1'b1;
        end else begin
          w_ny = w_ty + c_grid;
        end
      end
      c_op_left: begin
        if (w_tx < c_grid) begin
          w_nx   = w_x_max;
          w_jump = 1'b1;
        end else begin
          w_nx = w_tx - c_grid;
        end
      end
      c_op_right: begin
        if ((w_tx + c_grid) > w_x_max) begin
          w_nx   = 12'd0;
          w_jump = 1'b1;
        end else begin
          w_nx = w_tx + c_grid;
        end
      end
`else
      c_op_up:    w_ny = min12(sub0(w_ty, c_grid), w_y_max);
      c_op_down:  w_ny = min12(w_ty + c_grid, w_y_max);
      c_op_left:  w_nx = min12(sub0(w_tx, c_grid), w_x_max);
      c_op_right: w_nx = min12(w_tx + c_grid, w_x_max);
`endif
      c_op_grow: begin
        w_nw = min12(w_tw + c_grid, w_w_max);
        w_nh = min12(w_th + c_grid, w_h_max);
      end
      c_op_shrink: begin
        w_nw = max12(sub0(w_tw, c_grid), c_min_size);
        w_nh = max12(sub0(w_th, c_grid), c_min_size);
      end
      c_op_set: begin
        w_nx = min12({1'b0, cmd_x_in}, w_x_max);
        w_ny = min12({2'b00, cmd_y_in}, w_y_max);
      end
      default: ;  // NOP keeps targets
    endcase
  end

  logic w_differs;
  assign w_differs = (w_nx[10:0] != r_x) || (w_ny[9:0] != r_y) ||
                     (w_nw[10:0] != r_w) || (w_nh[9:0] != r_h);

  // One animation step of each live field.
  logic [11:0] w_sx, w_sy, w_sw, w_sh;
  logic        w_settled;

  assign w_sx = slew({1'b0, r_x}, w_tx);
  assign w_sy = slew({2'b00, r_y}, w_ty);
  assign w_sw = slew({1'b0, r_w}, w_tw);
  assign w_sh = slew({2'b00, r_h}, w_th);
  assign w_settled = (w_sx[10:0] == r_tx) && (w_sy[9:0] == r_ty) &&
                     (w_sw[10:0] == r_tw) && (w_sh[9:0] == r_th);

  // Upper bits of the 12-bit intermediates are always zero for legal geometry.
  logic w_unused;
  assign w_unused = &{1'b0, w_nx[11], w_ny[11:10], w_nw[11], w_nh[11:10],
                      w_sx[11], w_sy[11:10], w_sw[11], w_sh[11:10]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_jump  <= 1'b0;
      r_x     <= 11'(X_INIT);
      r_y     <= 10'(Y_INIT);
      r_w     <= 11'(W_INIT);
      r_h     <= 10'(H_INIT);
      r_tx    <= 11'(X_INIT);
      r_ty    <= 10'(Y_INIT);
      r_tw    <= 11'(W_INIT);
      r_th    <= 10'(H_INIT);
    end else begin
      case (r_state)
        ST_IDLE: begin
          // new_frame_in is deliberately ignored here; a command taken on a
          // frame pulse waits for the next one before the first step.
          if (cmd_valid_in && r_ready) begin
            r_tx   <= w_nx[10:0];
            r_ty   <= w_ny[9:0];
            r_tw   <= w_nw[10:0];
            r_th   <= w_nh[9:0];
            r_jump <= w_jump;
            if (w_differs) begin
              r_state <= ST_ANIM;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_ANIM: begin
          if (new_frame_in) begin
            if (r_jump || w_settled) begin
              r_x     <= r_tx;
              r_y     <= r_ty;
              r_w     <= r_tw;
              r_h     <= r_th;
              r_jump  <= 1'b0;
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_x <= w_sx[10:0];
              r_y <= w_sy[9:0];
              r_w <= w_sw[10:0];
              r_h <= w_sh[9:0];
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_out = r_ready;
  assign busy_out      = r_busy;
  assign x_out         = r_x;
  assign y_out         = r_y;
  assign width_out     = r_w;
  assign height_out    = r_h;

endmodule
`default_nettype wire

// File: tb/tb_frame_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sprite_ctrl
// Purpose  : Self-checking bench for frame_sprite_ctrl. A behavioural model
//            tracks live/target geometry as plain integers and every cycle's
//            DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sprite_ctrl;

  localparam int SW = 1280;
  localparam int SH = 720;
  localparam int G  = 16;
  localparam int ST = 4;
  localparam int MN = 16;

  localparam int OP_NOP = 0, OP_UP = 1, OP_DOWN = 2, OP_LEFT = 3, OP_RIGHT = 4,
                 OP_GROW = 5, OP_SHRINK = 6, OP_SET = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_frame = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [10:0] cmd_x = 11'd0;
  logic [9:0]  cmd_y = 10'd0;
  logic [10:0] x_o, w_o;
  logic [9:0]  y_o, h_o;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int lx, ly, lw, lh, tx, ty, tw, th;
  bit anim, jump;

  frame_sprite_ctrl dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .new_frame_in  (new_frame),
    .cmd_valid_in  (cmd_valid),
    .cmd_ready_out (cmd_ready),
    .cmd_op_in     (cmd_op),
    .cmd_x_in      (cmd_x),
    .cmd_y_in      (cmd_y),
    .x_out         (x_o),
    .y_out         (y_o),
    .width_out     (w_o),
    .height_out    (h_o),
    .busy_out      (busy)
  );

  always #5 clk = ~clk;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int iabs(int a); return (a < 0) ? -a : a; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"},     32'(x_o), 32'(lx));
    check({tag, ".y"},     32'(y_o), 32'(ly));
    check({tag, ".w"},     32'(w_o), 32'(lw));
    check({tag, ".h"},     32'(h_o), 32'(lh));
    check({tag, ".busy"},  32'(busy), 32'(anim));
    check({tag, ".ready"}, 32'(cmd_ready), 32'(!anim));
    check({tag, ".inv"},   32'((32'(x_o) + 32'(w_o) <= SW) && (32'(y_o) + 32'(h_o) <= SH)), 32'd1);
  endtask

  task automatic model_reset();
    lx = 0; ly = 0; lw = 64; lh = 64;
    tx = 0; ty = 0; tw = 64; th = 64;
    anim = 0; jump = 0;
  endtask

  // Target rules written straight from the command definitions.
  task automatic model_cmd(input int op, input int cx, input int cy);
    int nx, ny, nw, nh, v;
    bit j;
    nx = tx; ny = ty; nw = tw; nh = th; j = 0;
    case (op)
`ifdef FRAME_CTRL_WRAP_EN
      OP_UP:    begin v = ty - G; if (v < 0)       begin ny = SH - th; j = 1; end else ny = v; end
      OP_DOWN:  begin v = ty + G; if (v > SH - th) begin ny = 0;       j = 1; end else ny = v; end
      OP_LEFT:  begin v = tx - G; if (v < 0)       begin nx = SW - tw; j = 1; end else nx = v; end
      OP_RIGHT: begin v = tx + G; if (v > SW - tw) begin nx = 0;       j = 1; end else nx = v; end
`else
      OP_UP:    ny = imin(imax(ty - G, 0), SH - th);
      OP_DOWN:  ny = imin(ty + G, SH - th);
      OP_LEFT:  nx = imin(imax(tx - G, 0), SW - tw);
      OP_RIGHT: nx = imin(tx + G, SW - tw);
`endif
      OP_GROW:   begin nw = imin(tw + G, SW - tx); nh = imin(th + G, SH - ty); end
      OP_SHRINK: begin nw = imax(imax(tw - G, 0), MN); nh = imax(imax(th - G, 0), MN); end
      OP_SET:    begin nx = imin(cx, SW - tw); ny = imin(cy, SH - th); end
      default: ;
    endcase
    tx = nx; ty = ny; tw = nw; th = nh;
    if (nx != lx || ny != ly || nw != lw || nh != lh) begin
      anim = 1; jump = j;
    end
  endtask

  function automatic int step_toward(int l, int t);
    if (t > l) return l + imin(ST, t - l);
    return l - imin(ST, l - t);
  endfunction

  task automatic model_frame();
    if (jump) begin
      lx = tx; ly = ty; lw = tw; lh = th;
    end else begin
      lx = step_toward(lx, tx); ly = step_toward(ly, ty);
      lw = step_toward(lw, tw); lh = step_toward(lh, th);
    end
    if (lx == tx && ly == ty && lw == tw && lh == th) begin
      anim = 0; jump = 0;
    end
  endtask

  // One clock: drive at negedge, model the posedge, check at next negedge.
  task automatic cycle(input string tag, input bit v, input bit nf,
                       input int op, input int cx, input int cy);
    cmd_valid = v; new_frame = nf;
    cmd_op = 3'(op); cmd_x = 11'(cx); cmd_y = 10'(cy);
    @(posedge clk);
    if (!anim) begin
      if (v) model_cmd(op, cx, cy);
    end else if (nf) begin
      model_frame();
    end
    @(negedge clk);
    cmd_valid = 1'b0; new_frame = 1'b0;
    check_all(tag);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 400 && anim; i++) cycle(tag, 1'b0, 1'b1, OP_NOP, 0, 0);
    check({tag, ".settled"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_x[4];
    int op, k;
    exp_x = '{4, 8, 12, 16};
    model_reset();

    // 1. reset, idle frames
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    for (int i = 0; i < 3; i++) cycle("idle_frame", 1'b0, 1'b1, OP_NOP, 0, 0);
    check("reset_w", 32'(w_o), 32'd64);

    // 2. RIGHT slews x by 4 per frame
    cycle("right_cmd", 1'b1, 1'b0, OP_RIGHT, 0, 0);
    check("right_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle("right_frame", 1'b0, 1'b1, OP_NOP, 0, 0);
      check("right_x", 32'(x_o), 32'(exp_x[i]));
    end
    check("right_ready", 32'(cmd_ready), 32'd1);

    // 3. SET clamps to the right/bottom edge; command taken on a frame pulse
    cycle("set_cmd", 1'b1, 1'b1, OP_SET, 1250, 700);
    check("set_latency_x", 32'(x_o), 32'd16);
    settle("set");
    check("set_x", 32'(x_o), 32'd1216);
    check("set_y", 32'(y_o), 32'd656);
    check("set_edge", 32'(x_o) + 32'(w_o), 32'd1280);

    // 4. RIGHT at the right edge
    cycle("edge_right", 1'b1, 1'b0, OP_RIGHT, 0, 0);
`ifdef FRAME_CTRL_WRAP_EN
    cycle("edge_frame", 1'b0, 1'b1, OP_NOP, 0, 0);
    check("edge_wrap_x", 32'(x_o), 32'd0);
`else
    check("edge_busy", 32'(busy), 32'd0);
    cycle("edge_frame", 1'b0, 1'b1, OP_NOP, 0, 0);
    check("edge_x", 32'(x_o), 32'd1216);
`endif

    // 5. SHRINK down to the minimum size
    for (int i = 0; i < 4; i++) begin
      cycle("shrink_cmd", 1'b1, 1'b0, OP_SHRINK, 0, 0);
      settle("shrink");
    end
    check("shrink_w", 32'(w_o), 32'd16);
    check("shrink_h", 32'(h_o), 32'd16);
    cycle("shrink5", 1'b1, 1'b0, OP_SHRINK, 0, 0);
    check("shrink5_busy", 32'(busy), 32'd0);

    // 6. valid held during ANIM is ignored, then asynchronous reset
    cycle("anim_set", 1'b1, 1'b0, OP_SET, 600, 300);
    for (int i = 0; i < 6; i++) cycle("held_left", 1'b1, 1'(i % 2), OP_LEFT, 0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_rst");

    // 7. randomized commands and frame pulses
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      cycle("rnd_cmd", 1'b1, 1'($urandom_range(0, 1)), op,
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
      k = int'($urandom_range(0, 5));
      for (int i = 0; i < k; i++)
        cycle("rnd_frame", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              OP_LEFT, 0, 0);
      if (n % 8 == 7) settle("rnd");
    end
    settle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_sprite_ctrl.md
Name: frame_sprite_ctrl

Overview:
- Sequencer for the rectangular frame/cursor sprite datapath. Drives x, y, width and height, and accepts move/resize/set commands over a valid/ready handshake.
- Computes clamped targets and slews the live geometry toward them by at most STEP pixels per video frame. Updates happen only at frame boundaries, so the sprite never tears mid-frame.
- Sits between the input/game logic and the frame sprite instance in the video pipeline.

Parameters:
SCREEN_W, 1280, active width in pixels
SCREEN_H, 720, active height in lines
GRID, 16, pixel increment for move and grow/shrink commands
STEP, 4, maximum per-frame change of any geometry field during animation
MIN_SIZE, 16, minimum width and height
X_INIT, 0, reset x
Y_INIT, 0, reset y
W_INIT, 64, reset width
H_INIT, 64, reset height

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  reset; asynchronous assert, active-low
new_frame_in  input  1  one-cycle pulse at the start of vertical blanking
cmd_valid_in  input  1  command present
cmd_ready_out  output  1  controller can accept a command
cmd_op_in  input  3  0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 GROW, 6 SHRINK, 7 SET
cmd_x_in  input  11  SET target x
cmd_y_in  input  10  SET target y
x_out  output  11  live sprite x, to sprite x_in
y_out  output  10  live sprite y
width_out  output  11  live sprite width
height_out  output  10  live sprite height
busy_out  output  1  animation in progress

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - x/y/width/height outputs and targets = X_INIT/Y_INIT/W_INIT/H_INIT.
  - State IDLE; cmd_ready_out=1; busy_out=0.
- States:
  - IDLE: cmd_ready_out=1. A handshake (valid&&ready) computes new targets in that cycle; next state ANIM if any target differs from live, else stay IDLE. NOP never leaves IDLE.
  - ANIM: cmd_ready_out=0, busy_out=1. Commands are not accepted and valid is ignored.
- Animation step: on each new_frame_in in ANIM, each live field moves toward its target by min(STEP, |target-live|). All four fields update in the same cycle, visible the cycle after the pulse. If all fields equal their targets after the update, the next state is IDLE.
- new_frame_in in IDLE has no effect.
- Target computation uses 12-bit unsigned intermediates; no wrap.
  - UP/DOWN: ty = clamp(ty ∓ GRID, 0, SCREEN_H-th).
  - LEFT/RIGHT: tx = clamp(tx ∓ GRID, 0, SCREEN_W-tw).
  - GRROW: tw = min(tw+GRID, SCREEN_W-tx); th = min(th+GRID, SCREEN_H-ty). Position is unchanged.
  - SHRINK: tw = max(tw-GRID, MIN_SIZE); th = max(th-GRID, MIN_SIZE).
  - SET: tx = min(cmd_x_in, SCREEN_W-tw); ty = min(cmd_y_in, SCREEN_H-th).
  - Underflow of a subtraction clamps to 0 before the min/max.
- Invariant at all times: x_out+width_out ≤ SCREEN_W and y_out+height_out ≤ SCREEN_H. Because grow only increases size toward an already-legal bound, live geometry always satisfies the invariant while animating.
- Simultaneous handshake and new_frame_in in IDLE: the command is taken. Live fields do not step until the next new_frame_in, giving a minimum latency of one full frame.
- Reset mid-animation: all fields snap to INIT values immediately; the pending target is discarded.
- Outputs are registered; there is no combinational path from cmd_*_in to geometry outputs.

Optional Feature:
- Macro FRAME_CTRL_WRAP_EN.
- Defined: UP/DOWN/LEFT/RIGHT targets wrap modulo the legal range instead of clamping.
  - x: past SCREEN_W-tw wraps to 0; below 0 wraps to SCREEN_W-tw.
  - y: same rule using SCREEN_H-th.
  - A wrapping move jumps live position to target at the next new_frame_in with no slew; busy_out clears that frame.
- Undefined: clamp behaviour as above. GROW/SHRINK/SET are unaffected in both builds.

Test Plan:
1. Reset, no commands, 3 new_frame pulses -> x=0, y=0, w=64, h=64, cmd_ready_out=1, busy_out=0 throughout.
2. RIGHT from reset, then 4 new_frame pulses -> x_out goes 4, 8, 12, 16. busy_out=1 until after the 4th pulse; cmd_ready_out=1 the cycle after x=16.
3. SET x=1250, y=700 with w=h=64 -> targets 1216/656. After the final frame x=1216, y=656, and x+w=1280 exactly.
4. At x=1216, issue RIGHT -> no target change, stays IDLE, busy_out never asserts. With FRAME_CTRL_WRAP_EN, x jumps to 0 one frame later.
5. SHRINK ×4 from 64×64 (waiting for IDLE between commands) -> width/height settle at 16 and stay 16; a 5th SHRINK causes no ANIM.
6. cmd_valid_in held high during ANIM with op=LEFT -> not accepted. Assert rst_n_in low mid-animation -> outputs return to INIT asynchronously, state IDLE.
